// File: rtl/key_scan_ctrl_pkg.sv
// Shared definitions for key_scan_ctrl: FSM state encoding and counter sizing helper.
package key_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_scan_ctr.sv
// Keyboard matrix scan address counter: advances on enable, wraps naturally, synchronous clear.
module key_scan_ctr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/key_scan_ctrl.sv
// Keyboard scan/debounce controller: scans the matrix, debounces one key, latches its code, pulses IRQ.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module key_scan_ctrl
  import key_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEB_SCANS = 2
`ifdef KEY_REPEAT_EN
  ,
  parameter int REP_DELAY = 32,
  parameter int REP_RATE  = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scanEn,
  input  logic              debEn,
  input  logic              scanTick,
  input  logic              iKR1,
  input  logic              iShift,
  output logic [ADDR_W-1:0] keyAddr,
  output logic [ADDR_W:0]   kbCode,
  output logic              keyIrq,
  output logic              keyDown
);

  localparam int HIT_W = cnt_w(DEB_SCANS);
  localparam logic [HIT_W-1:0] DEB_TGT = HIT_W'(DEB_SCANS);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_comp, w_comp_next;
  logic [HIT_W-1:0]  r_hit_cnt, w_hit_next;
  logic [ADDR_W:0]   r_kb_code, w_code_next;
  logic              r_irq, w_irq_next;
  logic              r_down, w_down_next;
  logic              w_accept;
  logic              w_comp_hit;
  logic [ADDR_W-1:0] w_addr;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = cnt_w(REP_DELAY);
  localparam logic [REP_W-1:0] REP_TGT    = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_RATE);
  logic [REP_W-1:0]  r_rep_cnt, w_rep_next;
`endif

  key_scan_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!scanEn),
    .i_en   (scanTick),
    .o_addr (w_addr)
  );

  assign w_comp_hit = (w_addr == r_comp);

  always_comb begin
    w_state_next = r_state;
    w_comp_next  = r_comp;
    w_hit_next   = r_hit_cnt;
    w_code_next  = r_kb_code;
    w_irq_next   = 1'b0;
    w_down_next  = r_down;
    w_accept     = 1'b0;
`ifdef KEY_REPEAT_EN
    w_rep_next   = r_rep_cnt;
`endif
    if (scanTick) begin
      case (r_state)
        ST_IDLE: begin
          if (!iKR1) begin
            w_comp_next = w_addr;
            w_hit_next  = HIT_W'(1);
            if (DEB_SCANS <= 1 || !debEn) w_accept = 1'b1;
            else                          w_state_next = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (w_comp_hit) begin
            if (!iKR1) begin
              w_hit_next = r_hit_cnt + 1'b1;
              if (w_hit_next >= DEB_TGT || !debEn) w_accept = 1'b1;
            end else begin
              w_state_next = ST_IDLE;
            end
          end
        end
        ST_HELD: begin
          if (w_comp_hit) begin
            if (iKR1) begin
              if (debEn) begin
                w_state_next = ST_RELEASE;
              end else begin
                w_state_next = ST_IDLE;
                w_down_next  = 1'b0;
              end
            end
`ifdef KEY_REPEAT_EN
            // First repeat after REP_DELAY scans; reloading keeps later ones REP_RATE apart.
            else if (r_rep_cnt + 1'b1 == REP_TGT) begin
              w_rep_next  = REP_RELOAD;
              w_code_next = {~iShift, r_comp};
              w_irq_next  = 1'b1;
            end else begin
              w_rep_next = r_rep_cnt + 1'b1;
            end
`endif
          end
        end
        ST_RELEASE: begin
          if (w_comp_hit) begin
            if (iKR1) begin
              w_state_next = ST_IDLE;
              w_down_next  = 1'b0;
            end else begin
              w_state_next = ST_HELD;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
      if (w_accept) begin
        w_code_next  = {~iShift, w_comp_next};
        w_irq_next   = 1'b1;
        w_down_next  = 1'b1;
        w_state_next = ST_HELD;
      end
    end
`ifdef KEY_REPEAT_EN
    if (w_state_next != ST_HELD) w_rep_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || !scanEn) begin
      r_state   <= ST_IDLE;
      r_comp    <= '0;
      r_hit_cnt <= '0;
      r_irq     <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_comp    <= w_comp_next;
      r_hit_cnt <= w_hit_next;
      r_irq     <= w_irq_next;
      r_down    <= w_down_next;
    end
  end

  // The latched code survives a scan disable; only a real reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kb_code <= '0;
    end else if (scanEn) begin
      r_kb_code <= w_code_next;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset || !scanEn) r_rep_cnt <= '0;
    else                  r_rep_cnt <= w_rep_next;
  end
`endif

  assign keyAddr = w_addr;
  assign kbCode  = r_kb_code;
  assign keyIrq  = r_irq;
  assign keyDown = r_down;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Testbench for key_scan_ctrl: scripted key scenarios plus random presses, scoreboard on keyIrq.
module tb_key_scan_ctrl;

  localparam int ADDR_W    = 6;
  localparam int NKEYS     = 64;
  localparam int DEB_SCANS = 2;

  logic       clk = 1'b0;
  logic       reset, scanEn, debEn, scanTick, iKR1, iShift;
  logic [5:0] keyAddr;
  logic [6:0] kbCode;
  logic       keyIrq, keyDown;

  int checks   = 0;
  int failures = 0;
  int irq_seen = 0;

  // Stimulus: which matrix keys are physically pressed, plus the shift line (active low).
  bit pressed [NKEYS];
  bit shift_n = 1'b1;

  // Reference model state (key-level view of the controller).
  int         m_addr;
  int         m_lock;
  int         m_hits;
  bit         m_down;
  bit         m_gone;
  int         m_held_scans;
  logic [6:0] m_code;
  logic [6:0] exp_q [$];

  key_scan_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .scanEn   (scanEn),
    .debEn    (debEn),
    .scanTick (scanTick),
    .iKR1     (iKR1),
    .iShift   (iShift),
    .keyAddr  (keyAddr),
    .kbCode   (kbCode),
    .keyIrq   (keyIrq),
    .keyDown  (keyDown)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    m_addr = 0; m_lock = -1; m_hits = 0;
    m_down = 1'b0; m_gone = 1'b0; m_held_scans = 0;
  endtask

  task automatic model_accept(input bit sh_n);
    m_code = {~sh_n, 6'(m_lock)};
    exp_q.push_back(m_code);
    m_down = 1'b1;
    m_gone = 1'b0;
    m_held_scans = 0;
  endtask

  // One scan step: a key is considered only when it is seen at the scan position.
  task automatic model_step(input bit k, input bit sh_n);
    int a;
    a = m_addr;
    if (m_lock < 0) begin
      if (k) begin
        m_lock = a;
        m_hits = 1;
        if (DEB_SCANS <= 1 || !debEn) model_accept(sh_n);
      end
    end else if (a == m_lock) begin
      if (!m_down) begin
        if (k) begin
          m_hits++;
          if (m_hits >= DEB_SCANS || !debEn) model_accept(sh_n);
        end else begin
          m_lock = -1;
        end
      end else if (!m_gone) begin
        if (!k) begin
          m_held_scans = 0;
          if (debEn) m_gone = 1'b1;
          else begin
            m_down = 1'b0;
            m_lock = -1;
          end
        end else begin
          m_held_scans++;
`ifdef KEY_REPEAT_EN
          if (m_held_scans >= 32 && (m_held_scans - 32) % 4 == 0) begin
            m_code = {~sh_n, 6'(m_lock)};
            exp_q.push_back(m_code);
          end
`endif
        end
      end else begin
        m_gone = 1'b0;
        if (!k) begin
          m_down = 1'b0;
          m_lock = -1;
        end
      end
    end
    m_addr = (a + 1) % NKEYS;
  endtask

  task automatic tick();
    @(negedge clk);
    scanTick = 1'b1;
    iKR1     = ~pressed[m_addr];
    iShift   = shift_n;
    @(posedge clk);
    model_step(!iKR1, iShift);
    #1;
    scanTick = 1'b0;
    check("keyAddr", int'(keyAddr), m_addr);
    check("keyDown", int'(keyDown), int'(m_down));
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int addr);
    for (int i = 0; i < NKEYS && m_addr != addr; i++) tick();
  endtask

  task automatic release_all();
    for (int i = 0; i < NKEYS; i++) pressed[i] = 1'b0;
  endtask

  // Monitor: every IRQ pulse must match the next expected code from the model.
  always @(negedge clk) begin
    if (!reset && keyIrq) begin
      logic [6:0] e;
      irq_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL irq_unexpected actual kbCode=0x%0h required no irq", kbCode);
      end else begin
        e = exp_q.pop_front();
        if (kbCode !== e) begin
          failures++;
          $display("FAIL irq_kbCode actual=0x%0h required=0x%0h", kbCode, e);
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1; scanEn = 1'b1; debEn = 1'b1; scanTick = 1'b1; iKR1 = 1'b1; iShift = 1'b1;
    release_all();
    m_code = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_keyAddr", int'(keyAddr), 0);
    check("reset_kbCode", int'(kbCode), 0);
    check("reset_keyIrq", int'(keyIrq), 0);
    check("reset_keyDown", int'(keyDown), 0);
    @(negedge clk);
    reset = 1'b0; scanTick = 1'b0;

    // Idle scan with wrap, no key pressed.
    base = irq_seen;
    run_ticks(70);
    check("idle_irqs", irq_seen - base, 0);

    // Debounced press of 0x12 over three scans.
    debEn = 1'b1;
    run_to(8'h12);
    pressed[8'h12] = 1'b1;
    base = irq_seen;
    run_ticks(3 * NKEYS);
    check("deb_irqs", irq_seen - base, 1);
    check("deb_kbCode", int'(kbCode), 8'h12);
    release_all();
    run_ticks(2 * NKEYS);
    check("deb_release_down", int'(keyDown), 0);

    // One-scan press is rejected.
    run_to(8'h12);
    pressed[8'h12] = 1'b1;
    base = irq_seen;
    run_ticks(NKEYS);
    release_all();
    run_ticks(NKEYS);
    check("short_irqs", irq_seen - base, 0);

    // Debounce off, shifted key 0x05.
    debEn = 1'b0; shift_n = 1'b0;
    run_to(8'h05);
    pressed[8'h05] = 1'b1;
    base = irq_seen;
    run_ticks(NKEYS);
    check("nodeb_irqs", irq_seen - base, 1);
    check("nodeb_kbCode", int'(kbCode), 8'h45);
    release_all();
    shift_n = 1'b1;
    run_ticks(NKEYS);
    check("nodeb_release_down", int'(keyDown), 0);

    // Bounce while held; a second key is ignored meanwhile.
    debEn = 1'b1;
    run_to(8'h12);
    pressed[8'h12] = 1'b1;
    run_ticks(3 * NKEYS);
    run_to(8'h13);
    base = irq_seen;
    pressed[8'h12] = 1'b0; pressed[8'h20] = 1'b1;
    run_ticks(NKEYS);
    pressed[8'h12] = 1'b1;
    run_ticks(NKEYS);
    check("bounce_down", int'(keyDown), 1);
    check("bounce_irqs", irq_seen - base, 0);
    check("bounce_kbCode", int'(kbCode), 8'h12);
    release_all();
    run_ticks(3 * NKEYS);

    // Scan disable while a key is held: clears everything but the code.
    pressed[8'h30] = 1'b1;
    run_ticks(3 * NKEYS);
    @(negedge clk);
    scanEn = 1'b0; scanTick = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check("scanoff_keyAddr", int'(keyAddr), 0);
    check("scanoff_keyDown", int'(keyDown), 0);
    check("scanoff_kbCode", int'(kbCode), int'(m_code));
    @(negedge clk);
    scanEn = 1'b1; scanTick = 1'b0;
    release_all();
    run_ticks(3 * NKEYS);

`ifdef KEY_REPEAT_EN
    // Auto-repeat: accept, then +32, +36, +40 held scans.
    debEn = 1'b1;
    run_to(8'h12);
    pressed[8'h12] = 1'b1;
    base = irq_seen;
    run_ticks(42 * NKEYS);
    check("repeat_irqs", irq_seen - base, 4);
    release_all();
    run_ticks(2 * NKEYS);
`endif

    // Random presses, debounce modes, shift and holds.
    for (int it = 0; it < 12; it++) begin
      debEn   = 1'($urandom_range(0, 1));
      shift_n = 1'($urandom_range(0, 1));
      pressed[$urandom_range(0, NKEYS - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, NKEYS - 1)] = 1'b1;
      run_ticks($urandom_range(0, 4) * NKEYS + $urandom_range(0, NKEYS - 1));
      release_all();
      run_ticks(2 * NKEYS + $urandom_range(0, 20));
    end
    run_ticks(2 * NKEYS);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_keyDown", int'(keyDown), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
